reg_file_np: RTL and testbench

REG_FILE_NP -- requirements
Module: reg_file_np

---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_file_wr_arb.sv | 38 +++
 rtl/reg_file_np.sv | 123 ++++++++++++
 tb/tb_reg_file_np.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the multi-port register file.
package reg_file_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_NRD    = 2;
    localparam int DEF_NWR    = 2;

    // Low bit of field idx inside a packed bus of width-bit fields.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/reg_file_wr_arb.sv
// Write arbiter: turns the pending write stages plus the late write data
// into one strobe and one data word per register address.
// When several ports hit the same address, the highest port index wins.
module reg_file_wr_arb
    import reg_file_pkg::*;
#(
    parameter int  DATA_W  = DEF_DATA_W,
    parameter int  ADDR_W  = DEF_ADDR_W,
    parameter int  NWR     = DEF_NWR,
    parameter int  ZERO_R0 = 0,
    localparam int DEPTH   = 2**ADDR_W
) (
    input  logic [NWR-1:0]          pend_en_i,
    input  logic [NWR*ADDR_W-1:0]   pend_addr_i,
    input  logic [NWR*DATA_W-1:0]   wr_data_i,
    output logic [DEPTH-1:0]        wr_stb_o,
    output logic [DEPTH*DATA_W-1:0] wr_data_o
);

    // Scan ports low to high per address so the last (highest) match overrides.
    always_comb begin
        // NOTE: both outputs get a default before the loops, so every path assigns them and no latch is inferred.
        wr_stb_o  = '0;
        wr_data_o = '0;
        for (int a = 0; a < DEPTH; a++) begin
            for (int k = 0; k < NWR; k++) begin
                if (pend_en_i[k]
                    && (pend_addr_i[slice_lo(k, ADDR_W) +: ADDR_W] == ADDR_W'(a))
                    && !((ZERO_R0 != 0) && (a == 0))) begin
                    wr_stb_o[a] = 1'b1;
                    wr_data_o[slice_lo(a, DATA_W) +: DATA_W] =
                        wr_data_i[slice_lo(k, DATA_W) +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_np.sv
// Multi-port register file with split write (command one edge, data the
// next), optional hard-wired zero register, optional same-edge bypass,
// per-port immediate select and a combinational hazard flag.
module reg_file_np
    import reg_file_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NRD     = DEF_NRD,
    parameter int NWR     = DEF_NWR,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_N,
    input  logic [NRD*ADDR_W-1:0] i_AddrRd,
    input  logic [NRD-1:0]        i_SelImm,
    input  logic [NRD*DATA_W-1:0] i_Imm,
    input  logic [NWR-1:0]        i_WrEn,
    input  logic [NWR*ADDR_W-1:0] i_WrAddr,
    input  logic [NWR*DATA_W-1:0] i_WrData,
    output logic [NRD*DATA_W-1:0] o_RdData,
    output logic [NRD*DATA_W-1:0] o_Show,
    output logic [NRD-1:0]        o_Pending
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]       regs_q [DEPTH];
    logic [NWR-1:0]          pend_en_q;
    logic [NWR*ADDR_W-1:0]   pend_addr_q;
    logic [DEPTH-1:0]        wr_stb;
    logic [DEPTH*DATA_W-1:0] wr_data;
    logic [NRD*DATA_W-1:0]   rd_data_d;
    logic [NRD*DATA_W-1:0]   rd_data_q;

    // Pending stage: hold each write command one edge until its data arrives.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!i_RST_N) begin
            pend_en_q   <= '0;
            pend_addr_q <= '0;
        end else begin
            pend_en_q   <= i_WrEn;
            pend_addr_q <= i_WrAddr;
        end
    end

    reg_file_wr_arb #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NWR     (NWR),
        .ZERO_R0 (ZERO_R0)
    ) u_wr_arb (
        .pend_en_i   (pend_en_q),
        .pend_addr_i (pend_addr_q),
        .wr_data_i   (i_WrData),
        .wr_stb_o    (wr_stb),
        .wr_data_o   (wr_data)
    );

    // Register storage: commit the arbitrated write data per address.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            // NOTE: the whole array is reset because never-written registers must read zero; this keeps it in flops, not RAM.
            for (int a = 0; a < DEPTH; a++) begin
                regs_q[a] <= '0;
            end
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (wr_stb[a]) begin
                    regs_q[a] <= wr_data[slice_lo(a, DATA_W) +: DATA_W];
                end
            end
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              zero_hit;
        logic [DATA_W-1:0] reg_val;
        logic [DATA_W-1:0] fwd_val;
        logic              hazard;

        assign addr     = i_AddrRd[slice_lo(j, ADDR_W) +: ADDR_W];
        assign zero_hit = (ZERO_R0 != 0) && (addr == '0);
        assign reg_val  = zero_hit ? '0 : regs_q[addr];
        // Address 0 never strobes under ZERO_R0, so the bypass cannot leak a value there.
        assign fwd_val  = ((BYPASS != 0) && wr_stb[addr])
                          ? wr_data[slice_lo(int'(addr), DATA_W) +: DATA_W]
                          : reg_val;

        // Hazard flag: this read address matches a write whose data lands next edge.
        always_comb begin
            hazard = 1'b0;
            for (int k = 0; k < NWR; k++) begin
                if (pend_en_q[k] && (pend_addr_q[slice_lo(k, ADDR_W) +: ADDR_W] == addr)) begin
                    hazard = 1'b1;
                end
            end
            if (zero_hit) begin
                hazard = 1'b0;
            end
        end

        assign o_Pending[j]                             = hazard;
        assign o_Show[slice_lo(j, DATA_W) +: DATA_W]    = reg_val;
        assign rd_data_d[slice_lo(j, DATA_W) +: DATA_W] =
            i_SelImm[j] ? i_Imm[slice_lo(j, DATA_W) +: DATA_W] : fwd_val;
    end

    // Read data register: immediate or (possibly forwarded) register value.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign o_RdData = rd_data_q;

endmodule

// File: tb/tb_reg_file_np.sv
// Scoreboard bench for reg_file_np: three instances (default, no bypass,
// zero register) share one stimulus stream and one behavioural model.
module tb_reg_file_np;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 8;
    localparam int NC    = 3;   // 0: defaults, 1: BYPASS=0, 2: ZERO_R0=1

    typedef struct {
        int            c;
        int            j;
        int            cyc;
        logic [DW-1:0] exp;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR*AW-1:0] addr_rd;
    logic [NR-1:0]    sel_imm;
    logic [NR*DW-1:0] imm;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;

    logic [NR*DW-1:0] rd_data [NC];
    logic [NR*DW-1:0] show    [NC];
    logic [NR-1:0]    pend    [NC];

    logic [DW-1:0] m_regs [NC][DEPTH];
    bit            m_pen   [NW];
    int            m_paddr [NW];
    exp_t          sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;

    always #5 clk = ~clk;

    reg_file_np #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .ZERO_R0(0), .BYPASS(1)) u_dut_def (
        .i_CLK(clk), .i_RST_N(rst_n), .i_AddrRd(addr_rd), .i_SelImm(sel_imm), .i_Imm(imm),
        .i_WrEn(wr_en), .i_WrAddr(wr_addr), .i_WrData(wr_data),
        .o_RdData(rd_data[0]), .o_Show(show[0]), .o_Pending(pend[0])
    );

    reg_file_np #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .ZERO_R0(0), .BYPASS(0)) u_dut_nobyp (
        .i_CLK(clk), .i_RST_N(rst_n), .i_AddrRd(addr_rd), .i_SelImm(sel_imm), .i_Imm(imm),
        .i_WrEn(wr_en), .i_WrAddr(wr_addr), .i_WrData(wr_data),
        .o_RdData(rd_data[1]), .o_Show(show[1]), .o_Pending(pend[1])
    );

    reg_file_np #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .ZERO_R0(1), .BYPASS(1)) u_dut_zero (
        .i_CLK(clk), .i_RST_N(rst_n), .i_AddrRd(addr_rd), .i_SelImm(sel_imm), .i_Imm(imm),
        .i_WrEn(wr_en), .i_WrAddr(wr_addr), .i_WrData(wr_data),
        .o_RdData(rd_data[2]), .o_Show(show[2]), .o_Pending(pend[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit zero_addr(input int c, input int a);
        return (c == 2) && (a == 0);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            for (int a = 0; a < DEPTH; a++) begin
                m_regs[c][a] = '0;
            end
        end
        for (int k = 0; k < NW; k++) begin
            m_pen[k]   = 1'b0;
            m_paddr[k] = 0;
        end
    endtask

    task automatic set_idle();
        wr_en   = '0;
        sel_imm = '0;
    endtask

    task automatic set_wr(input int k, input bit en, input int a);
        wr_en[k]           = en;
        wr_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic set_wdata(input int k, input logic [DW-1:0] d);
        wr_data[k*DW +: DW] = d;
    endtask

    task automatic set_rd(input int j, input int a);
        addr_rd[j*AW +: AW] = AW'(a);
    endtask

    // One clock: check combinational outputs, predict the edge, then score it.
    task automatic cycle();
        logic [DEPTH-1:0] wm;
        logic [DW-1:0]    wd [DEPTH];
        logic [DW-1:0]    e;
        logic             hz;
        int               a;
        exp_t             item;
        #1;
        for (int c = 0; c < NC; c++) begin
            for (int j = 0; j < NR; j++) begin
                a  = int'(addr_rd[j*AW +: AW]);
                e  = zero_addr(c, a) ? '0 : m_regs[c][a];
                check($sformatf("show c%0d p%0d a%0d cyc%0d", c, j, a, cyc_n),
                      32'(show[c][j*DW +: DW]), 32'(e));
                hz = 1'b0;
                for (int k = 0; k < NW; k++) begin
                    if (m_pen[k] && (m_paddr[k] == a)) hz = 1'b1;
                end
                if (zero_addr(c, a)) hz = 1'b0;
                check($sformatf("pending c%0d p%0d a%0d cyc%0d", c, j, a, cyc_n),
                      32'(pend[c][j]), 32'(hz));
            end
        end
        for (int c = 0; c < NC; c++) begin
            wm = '0;
            for (int x = 0; x < DEPTH; x++) wd[x] = '0;
            for (int k = 0; k < NW; k++) begin
                if (m_pen[k] && !zero_addr(c, m_paddr[k])) begin
                    wm[m_paddr[k]] = 1'b1;
                    wd[m_paddr[k]] = wr_data[k*DW +: DW];
                end
            end
            for (int j = 0; j < NR; j++) begin
                a = int'(addr_rd[j*AW +: AW]);
                e = zero_addr(c, a) ? '0 : m_regs[c][a];
                if ((c != 1) && wm[a]) e = wd[a];
                if (sel_imm[j]) e = imm[j*DW +: DW];
                item.c   = c;
                item.j   = j;
                item.cyc = cyc_n;
                item.exp = e;
                sb.push_back(item);
            end
            for (int x = 0; x < DEPTH; x++) begin
                if (wm[x]) m_regs[c][x] = wd[x];
            end
        end
        for (int k = 0; k < NW; k++) begin
            m_pen[k]   = wr_en[k];
            m_paddr[k] = int'(wr_addr[k*AW +: AW]);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            item = sb.pop_front();
            check($sformatf("rd c%0d p%0d cyc%0d", item.c, item.j, item.cyc),
                  32'(rd_data[item.c][item.j*DW +: DW]), 32'(item.exp));
        end
        cyc_n++;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b1;
        addr_rd = '0;
        imm     = '0;
        wr_addr = '0;
        wr_data = '0;
        set_idle();
        model_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("reset rd c%0d", c), 32'(rd_data[c]), 32'h0);
        end
        rst_n = 1'b1;

        // All addresses read zero after reset.
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, a);
            set_rd(1, DEPTH - 1 - a);
            cycle();
        end

        // Command on one edge, data on the next; hazard visible in between.
        set_idle(); set_wr(0, 1, 3); set_rd(0, 3); cycle();
        #1 check("pending r3 between edges", 32'(pend[0][0]), 32'h1);
        set_idle(); set_wdata(0, 8'hA5); cycle();
        set_idle(); cycle();
        check("r3 after commit", 32'(show[0][0 +: DW]), 32'hA5);

        // Same-address writes on both ports: port 1 wins.
        set_idle(); set_wr(0, 1, 5); set_wr(1, 1, 5); cycle();
        set_idle(); set_wdata(0, 8'h11); set_wdata(1, 8'h22); cycle();
        set_idle(); set_rd(1, 5); cycle();
        check("r5 priority", 32'(show[0][DW +: DW]), 32'h22);

        // Read on the commit edge: forwarded with bypass, old value without.
        set_idle(); set_wr(0, 1, 2); cycle();
        set_idle(); set_wdata(0, 8'h5C); set_rd(0, 2); cycle();
        check("bypass on", 32'(rd_data[0][0 +: DW]), 32'h5C);
        check("bypass off", 32'(rd_data[1][0 +: DW]), 32'h00);

        // Immediate select overrides the register, o_Show does not.
        set_idle(); set_wr(0, 1, 4); cycle();
        set_idle(); set_wdata(0, 8'h3C); cycle();
        set_idle(); set_rd(0, 4); sel_imm[0] = 1'b1; imm[0 +: DW] = 8'h7F; cycle();
        check("imm rd", 32'(rd_data[0][0 +: DW]), 32'h7F);
        check("imm show", 32'(show[0][0 +: DW]), 32'h3C);

        // Writes to address 0 are discarded only in the zero-register instance.
        set_idle(); set_wr(0, 1, 0); set_rd(0, 0); cycle();
        set_idle(); set_wdata(0, 8'hFF); cycle();
        set_idle(); cycle();
        check("r0 zero inst", 32'(rd_data[2][0 +: DW]), 32'h00);
        check("r0 default inst", 32'(rd_data[0][0 +: DW]), 32'hFF);

        // Reset lands between a command and its data: nothing may commit.
        set_idle(); set_wr(0, 1, 6); set_rd(0, 6); set_rd(1, 3); cycle();
        set_idle(); set_wdata(0, 8'hEE); rst_n = 1'b0;
        #1;
        model_reset();
        for (int c = 0; c < NC; c++) begin
            check($sformatf("async reset rd c%0d", c), 32'(rd_data[c]), 32'h0);
        end
        check("async reset show r3", 32'(show[0][DW +: DW]), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        set_wr(1, 1, 7); cycle();
        set_idle(); set_wdata(1, 8'h99); cycle();
        set_idle(); set_rd(1, 7); cycle();
        check("no commit after reset", 32'(show[0][0 +: DW]), 32'h00);
        check("first edge after reset", 32'(show[0][DW +: DW]), 32'h99);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            wr_en   = NW'($urandom_range(0, (1 << NW) - 1));
            wr_addr = NW*AW'($urandom);
            wr_data = NW*DW'($urandom);
            addr_rd = NR*AW'($urandom);
            imm     = NR*DW'($urandom);
            for (int j = 0; j < NR; j++) sel_imm[j] = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
